// File: rtl/mux_pkg.sv
// Shared constants and round-robin search helper for the N:1 pipelined selector.
package mux_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;
   localparam int unsigned RR_MAX_N = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of valid at or above ptr, wrapping modulo n (n <= 16, ptr < n).
   function automatic rr_pick_t rr_pick(input logic [15:0] valid, input logic [3:0] ptr,
                                        input int unsigned n);
      rr_pick_t   r;
      logic [4:0] j;
      r = '0;
      for (int unsigned i = 0; i < RR_MAX_N; i++) begin
         j = {1'b0, ptr} + 5'(i);
         if (32'(j) >= n) j = j - 5'(n);
         if (i < n && !r.found && valid[j[3:0]]) begin
            r.found = 1'b1;
            r.idx   = j[3:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: pointer register plus priority search from the pointer.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_valid,
   input  logic             i_advance,
   output logic [SEL_W-1:0] o_grant,
   output logic             o_found
);

   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_next;
   rr_pick_t         w_pick;

   // Search upward from the pointer for the first requesting channel.
   always_comb begin
      w_pick     = rr_pick(16'(i_valid), 4'(r_ptr), N);
      o_found    = w_pick.found;
      o_grant    = SEL_W'(w_pick.idx);
      w_ptr_next = (o_grant == SEL_W'(N - 1)) ? '0 : o_grant + SEL_W'(1);
   end

   // Pointer moves past the winner only when its word is actually accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 selector with valid/ready on every channel; explicit select or round-robin.
module mux_nx1_pipe
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N),
   parameter int unsigned MODE  = MODE_SEL
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err
);

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_src;
   logic             r_out_valid;
   logic             r_sel_err;

   logic             w_free;
   logic             w_sel_ok;
   logic             w_grant_ok;
   logic [SEL_W-1:0] w_grant;
   logic             w_gvalid;
   logic [WIDTH-1:0] w_gdata;
   logic             w_xfer;

   assign w_free   = !r_out_valid || out_ready;
   assign w_sel_ok = 32'(sel) < N;

   if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] w_rr_grant;
      logic             w_rr_found;

      rr_arbiter_n #(
         .N     (N),
         .SEL_W (SEL_W)
      ) u_arb (
         .clk       (clk),
         .rst       (rst),
         .i_valid   (in_valid),
         .i_advance (w_xfer),
         .o_grant   (w_rr_grant),
         .o_found   (w_rr_found)
      );

      assign w_grant    = w_rr_grant;
      assign w_grant_ok = w_rr_found;
   end else begin : g_sel
      assign w_grant    = sel;
      assign w_grant_ok = w_sel_ok;
   end

   // Decode the grant into channel data/valid and the one-hot ready vector.
   always_comb begin
      w_gvalid = 1'b0;
      w_gdata  = '0;
      in_ready = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (w_grant == SEL_W'(k)) begin
            w_gvalid = in_valid[k];
            w_gdata  = in_data[k*WIDTH +: WIDTH];
            if (w_grant_ok && !rst) in_ready[k] = w_free;
         end
      end
   end

   assign w_xfer = w_free && w_grant_ok && w_gvalid;

   // Output register: load on transfer, drop valid on drain, sticky select error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_out_data  <= w_gdata;
            r_out_src   <= w_grant;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (MODE == MODE_SEL && !w_sel_ok && |in_valid) r_sel_err <= 1'b1;
      end
   end

   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench: one explicit-select instance and one round-robin instance.
module tb_mux_nx1_pipe;

   logic         clk;
   logic         rst;

   logic [127:0] d0, d1;
   logic [3:0]   v0, v1, r0, r1;
   logic [2:0]   sel0, os0;
   logic [1:0]   sel1, os1;
   logic         ord0, ord1, ov0, ov1, se0, se1;
   logic [31:0]  od0, od1;

   int           total = 0;
   int           bad   = 0;

   mux_nx1_pipe #(.WIDTH(32), .N(4), .SEL_W(3), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(sel0),
      .out_data(od0), .out_src(os0), .out_valid(ov0), .out_ready(ord0), .sel_err(se0)
   );

   mux_nx1_pipe #(.WIDTH(32), .N(4), .SEL_W(2), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(sel1),
      .out_data(od1), .out_src(os1), .out_valid(ov1), .out_ready(ord1), .sel_err(se1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; v0 = 4'hF; v1 = 4'hF; ord0 = 1'b1; ord1 = 1'b1; sel0 = 3'd0; sel1 = 2'd0;
      d0 = '0; d1 = '0;
      #1;
      total++; if ({ov0, os0, od0, se0} !== 37'd0) begin bad++;
         $display("FAIL reset_out0: got %h want 0", {ov0, os0, od0, se0}); end
      total++; if (r0 !== 4'b0000) begin bad++;
         $display("FAIL reset_ready0: got %b want 0000", r0); end
      total++; if (r1 !== 4'b0000) begin bad++;
         $display("FAIL reset_ready1: got %b want 0000", r1); end
      repeat (2) tick();
      total++; if ({ov0, ov1, se0} !== 3'b000) begin bad++;
         $display("FAIL reset_held: got %b want 000", {ov0, ov1, se0}); end
      v0 = 4'h0; v1 = 4'h0;
      rst = 1'b0;
   endtask

   task automatic test_sel_basic;
      for (int k = 0; k < 4; k++) d0[k*32 +: 32] = 32'h1000_0000 + k;
      d0[2*32 +: 32] = 32'hDEAD_BEEF;
      sel0 = 3'd2; v0 = 4'b0100; ord0 = 1'b1;
      #1;
      total++; if (r0 !== 4'b0100) begin bad++;
         $display("FAIL sel_basic_ready: got %b want 0100", r0); end
      tick();
      total++; if ({ov0, os0, od0} !== {1'b1, 3'd2, 32'hDEAD_BEEF}) begin bad++;
         $display("FAIL sel_basic_out: got %h want %h", {ov0, os0, od0},
                  {1'b1, 3'd2, 32'hDEAD_BEEF}); end
      v0 = 4'b0000;
      tick();
      total++; if ({ov0, od0} !== {1'b0, 32'hDEAD_BEEF}) begin bad++;
         $display("FAIL sel_basic_drain: got %h want %h", {ov0, od0}, {1'b0, 32'hDEAD_BEEF}); end
   endtask

   task automatic test_backpressure;
      ord0 = 1'b0; sel0 = 3'd1; v0 = 4'b0010; d0[1*32 +: 32] = 32'h1111_1111;
      #1;
      total++; if (r0 !== 4'b0010) begin bad++;
         $display("FAIL bp_ready_empty: got %b want 0010", r0); end
      tick();
      sel0 = 3'd3; v0 = 4'b1000; d0[3*32 +: 32] = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (r0 !== 4'b0000) begin bad++;
            $display("FAIL bp_ready_stall%0d: got %b want 0000", i, r0); end
         tick();
         total++; if ({ov0, os0, od0} !== {1'b1, 3'd1, 32'h1111_1111}) begin bad++;
            $display("FAIL bp_hold%0d: got %h want %h", i, {ov0, os0, od0},
                     {1'b1, 3'd1, 32'h1111_1111}); end
      end
      ord0 = 1'b1;
      #1;
      total++; if (r0 !== 4'b1000) begin bad++;
         $display("FAIL bp_ready_release: got %b want 1000", r0); end
      tick();
      total++; if ({ov0, os0, od0} !== {1'b1, 3'd3, 32'h3333_3333}) begin bad++;
         $display("FAIL bp_refill: got %h want %h", {ov0, os0, od0},
                  {1'b1, 3'd3, 32'h3333_3333}); end
      v0 = 4'b0000;
      tick();
      total++; if (ov0 !== 1'b0) begin bad++;
         $display("FAIL bp_empty: got %b want 0", ov0); end
   endtask

   task automatic test_sel_err;
      sel0 = 3'd5; v0 = 4'b1111; ord0 = 1'b1;
      #1;
      total++; if (r0 !== 4'b0000) begin bad++;
         $display("FAIL selerr_ready: got %b want 0000", r0); end
      total++; if (se0 !== 1'b0) begin bad++;
         $display("FAIL selerr_pre: got %b want 0", se0); end
      tick();
      total++; if ({se0, ov0} !== 2'b10) begin bad++;
         $display("FAIL selerr_set: got %b want 10", {se0, ov0}); end
      v0 = 4'b0000; sel0 = 3'd0;
      repeat (2) tick();
      total++; if (se0 !== 1'b1) begin bad++;
         $display("FAIL selerr_sticky: got %b want 1", se0); end
      v0 = 4'b0001; d0[0 +: 32] = 32'h0A0A_0A0A;
      tick();
      total++; if ({se0, ov0, os0, od0} !== {1'b1, 1'b1, 3'd0, 32'h0A0A_0A0A}) begin bad++;
         $display("FAIL selerr_after_xfer: got %h want %h", {se0, ov0, os0, od0},
                  {1'b1, 1'b1, 3'd0, 32'h0A0A_0A0A}); end
      v0 = 4'b0000; ord0 = 1'b0;
   endtask

   task automatic test_rr_all;
      for (int k = 0; k < 4; k++) d1[k*32 +: 32] = 32'hA0 + k;
      v1 = 4'b1111; ord1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (r1 !== 4'(1 << (i % 4))) begin bad++;
            $display("FAIL rr_all_ready%0d: got %b want %b", i, r1, 4'(1 << (i % 4))); end
         tick();
         total++; if ({ov1, os1, od1} !== {1'b1, 2'(i % 4), 32'hA0 + 32'(i % 4)}) begin bad++;
            $display("FAIL rr_all_out%0d: got %h want %h", i, {ov1, os1, od1},
                     {1'b1, 2'(i % 4), 32'hA0 + 32'(i % 4)}); end
      end
   endtask

   task automatic test_rr_stall;
      ord1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (r1 !== 4'b0000) begin bad++;
            $display("FAIL rr_stall_ready%0d: got %b want 0000", i, r1); end
         tick();
         total++; if ({ov1, os1, od1} !== {1'b1, 2'd1, 32'hA1}) begin bad++;
            $display("FAIL rr_stall_hold%0d: got %h want %h", i, {ov1, os1, od1},
                     {1'b1, 2'd1, 32'hA1}); end
      end
      ord1 = 1'b1;
      #1;
      total++; if (r1 !== 4'b0100) begin bad++;
         $display("FAIL rr_stall_release_ready: got %b want 0100", r1); end
      tick();
      total++; if ({ov1, os1, od1} !== {1'b1, 2'd2, 32'hA2}) begin bad++;
         $display("FAIL rr_stall_release_out: got %h want %h", {ov1, os1, od1},
                  {1'b1, 2'd2, 32'hA2}); end
      v1 = 4'b0000; ord1 = 1'b0;
   endtask

   task automatic test_async_reset;
      #1;
      total++; if ({ov0, se0, ov1} !== 3'b111) begin bad++;
         $display("FAIL areset_pre: got %b want 111", {ov0, se0, ov1}); end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++; if ({ov0, od0, se0} !== 34'd0) begin bad++;
         $display("FAIL areset_dut0: got %h want 0", {ov0, od0, se0}); end
      total++; if ({ov1, os1, od1} !== 35'd0) begin bad++;
         $display("FAIL areset_dut1: got %h want 0", {ov1, os1, od1}); end
      #2;
      rst = 1'b0;
   endtask

   task automatic test_rr_pair;
      int e;
      ord1 = 1'b1; v1 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         e = (i % 2 == 0) ? 1 : 3;
         #1;
         total++; if (r1 !== 4'(1 << e)) begin bad++;
            $display("FAIL rr_pair_ready%0d: got %b want %b", i, r1, 4'(1 << e)); end
         tick();
         total++; if ({ov1, os1, od1} !== {1'b1, 2'(e), 32'hA0 + 32'(e)}) begin bad++;
            $display("FAIL rr_pair_out%0d: got %h want %h", i, {ov1, os1, od1},
                     {1'b1, 2'(e), 32'hA0 + 32'(e)}); end
      end
      v1 = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_sel_basic();
      test_backpressure();
      test_sel_err();
      test_rr_all();
      test_rr_stall();
      test_async_reset();
      test_rr_pair();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
